dequantize16: RTL

DEQUANTIZE16 -- requirements
Module: dequantize16

---
 rtl/quant_pkg.sv | 26 ++
 rtl/dequantize16_if.sv | 26 ++
 rtl/dequant_lane.sv | 40 ++++
 rtl/dequantize16.sv | 92 +++++++++
 4 files changed

// File: rtl/quant_pkg.sv
// Shared dequantizer constants, shadow-config type and reset defaults.
package quant_pkg;

  localparam int LANES_DEF    = 16;
  localparam int IN_BITS_DEF  = 8;
  localparam int OUT_BITS_DEF = 32;
  localparam int MULT_BITS    = 16;
  localparam int ZP_BITS      = 8;
  localparam int BEATS_BITS   = 16;

  typedef struct packed {
    logic [MULT_BITS-1:0]  mult;
    logic [ZP_BITS-1:0]    zp;
    logic                  symmetric;
    logic [BEATS_BITS-1:0] beats;
  } shadow_cfg_t;

  localparam shadow_cfg_t CFG_RESET = '{mult: 16'd1, zp: 8'd0, symmetric: 1'b1, beats: 16'd1};

  // A frame of 0 or 1 beats marks every beat as last.
  function automatic logic beat_is_last(input logic [BEATS_BITS-1:0] cnt,
                                        input logic [BEATS_BITS-1:0] beats);
    return (beats <= 16'd1) || (cnt == beats - 16'd1);
  endfunction

endpackage

// File: rtl/dequantize16_if.sv
// Input/output stream bundle for dequantize16; master drives beats in and accepts results.
interface dequantize16_if
  import quant_pkg::*;
#(
  parameter int LANES    = LANES_DEF,
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*IN_BITS-1:0]  in_q;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*OUT_BITS-1:0] out_acc;
  logic                      out_last;

  modport master (
    output in_valid, in_q, out_ready,
    input  in_ready, out_valid, out_acc, out_last
  );

  modport slave (
    input  in_valid, in_q, out_ready,
    output in_ready, out_valid, out_acc, out_last
  );
endinterface

// File: rtl/dequant_lane.sv
// One dequantizer lane: S1 zero-point subtract, S2 multiply+round, S3 shift/extend.
// DEQUANTIZE16_ROUND_EN selects round-half-up instead of floor.
module dequant_lane
  import quant_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF,
  parameter int SHIFT    = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        adv,
  input  logic signed [IN_BITS-1:0]   q,
  input  logic signed [ZP_BITS-1:0]   zp,
  input  logic signed [MULT_BITS-1:0] mult,
  output logic signed [OUT_BITS-1:0]  acc
);
  localparam int DW = ((IN_BITS > ZP_BITS) ? IN_BITS : ZP_BITS) + 1;
  localparam int SW = DW + MULT_BITS + 1;
`ifdef DEQUANTIZE16_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'((1 << SHIFT) / 2);
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  logic signed [DW-1:0] d_r;
  logic signed [SW-1:0] s_r;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      d_r <= '0;
      s_r <= '0;
      acc <= '0;
    end else if (adv) begin
      d_r <= DW'(q) - DW'(zp);
      s_r <= SW'(d_r) * SW'(mult) + RND;
      acc <= OUT_BITS'(s_r >>> SHIFT);
    end
  end
endmodule

// File: rtl/dequantize16.sv
// Multi-lane int8 -> accumulator-domain dequantizer: shared stall, shadowed config
// applied only on an empty pipeline, and an output-side frame beat counter.
module dequantize16
  import quant_pkg::*;
#(
  parameter int LANES    = LANES_DEF,
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF,
  parameter int SHIFT    = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  dequantize16_if.slave         bus,
  input  logic                  cfg_load,
  input  logic [MULT_BITS-1:0]  cfg_mult_scalar,
  input  logic [ZP_BITS-1:0]    cfg_zp_in,
  input  logic                  cfg_symmetric,
  input  logic [BEATS_BITS-1:0] cfg_beats,
  output logic                  busy
);
  shadow_cfg_t             cfg_r, pend_cfg_r, pin_cfg, apply_cfg;
  logic                    pend_r, v1_r, v2_r, v3_r;
  logic [BEATS_BITS-1:0]   cnt_r;
  logic                    adv, empty, apply, take, out_fire, last_beat, in_ready_c;
  logic [ZP_BITS-1:0]      zp_eff;
  logic [LANES*OUT_BITS-1:0] acc_all;

  always_comb begin
    pin_cfg    = '{mult: cfg_mult_scalar, zp: cfg_zp_in, symmetric: cfg_symmetric, beats: cfg_beats};
    adv        = !v3_r || bus.out_ready;
    empty      = !(v1_r || v2_r || v3_r);
    // A fresh cfg_load wins over older pending values.
    apply      = (cfg_load || pend_r) && empty;
    apply_cfg  = cfg_load ? pin_cfg : pend_cfg_r;
    in_ready_c = adv && !pend_r && !cfg_load;
    take       = bus.in_valid && in_ready_c;
    out_fire   = v3_r && bus.out_ready;
    last_beat  = beat_is_last(cnt_r, cfg_r.beats);
    zp_eff     = cfg_r.symmetric ? '0 : cfg_r.zp;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      v1_r       <= 1'b0;
      v2_r       <= 1'b0;
      v3_r       <= 1'b0;
      pend_r     <= 1'b0;
      pend_cfg_r <= CFG_RESET;
      cfg_r      <= CFG_RESET;
      cnt_r      <= '0;
    end else begin
      if (adv) begin
        v1_r <= take;
        v2_r <= v1_r;
        v3_r <= v2_r;
      end
      if (apply) begin
        cfg_r  <= apply_cfg;
        pend_r <= 1'b0;
        cnt_r  <= '0;
      end else begin
        if (cfg_load) begin
          pend_r     <= 1'b1;
          pend_cfg_r <= pin_cfg;
        end
        if (out_fire) cnt_r <= last_beat ? '0 : cnt_r + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dequant_lane #(
      .IN_BITS (IN_BITS),
      .OUT_BITS(OUT_BITS),
      .SHIFT   (SHIFT)
    ) u_lane (
      .CLK  (CLK),
      .RESET(RESET),
      .adv  (adv),
      .q    (bus.in_q[i*IN_BITS +: IN_BITS]),
      .zp   (zp_eff),
      .mult (cfg_r.mult),
      .acc  (acc_all[i*OUT_BITS +: OUT_BITS])
    );
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = v3_r;
  assign bus.out_last  = v3_r && last_beat;
  assign bus.out_acc   = acc_all;
  assign busy          = v1_r || v2_r || v3_r || pend_r;
endmodule
